// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, alu opcode encodings and flag bit positions
//
// Purpose : common definitions for the alu issue stage and its register file.
// Contents: CPU_BW / CPU_NREG defaults, alu_op_t with the alu opcode encodings,
//           FLAG_* bit indices into the {overflow, negative, zero} flag vector.
package cpu_pkg;

    localparam int CPU_BW   = 16;
    localparam int CPU_NREG = 8;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 3'd0;
    localparam alu_op_t ALU_SUB  = 3'd1;
    localparam alu_op_t ALU_AND  = 3'd2;
    localparam alu_op_t ALU_OR   = 3'd3;
    localparam alu_op_t ALU_XOR  = 3'd4;
    localparam alu_op_t ALU_SHL  = 3'd5;
    localparam alu_op_t ALU_SHR  = 3'd6;
    localparam alu_op_t ALU_PASS = 3'd7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - NREG x BW register file, r0 hardwired to zero
//
// Purpose : operand storage for the alu issue stage.
// Ports   : clk, rst_n (sync active-low clear of every entry)
//           we/waddr/wdata  - synchronous write port, writes to r0 dropped
//           raddr_a/rdata_a - combinational operand A read
//           raddr_b/rdata_b - combinational operand B read
//           dbg_addr/dbg_data - combinational debug read
// Reads see the pre-edge contents; there is no write-through path.
module regfile #(
    parameter  int BW   = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [BW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [BW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [BW-1:0] dbg_data
);

    logic [BW-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : r_mem[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : r_mem[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage issue/writeback feeder for a combinational alu
//
// Purpose : accepts one instruction per cycle, reads operands from the register
//           file, presents registered operands/opcode to the external alu and
//           writes the alu result back one edge later, latching alu flags.
// Config  : ALU_ISSUE_BYPASS_EN - forward alu_out into a dependent operand
//           capture instead of stalling one cycle on a RAW hazard.
// Ports   : clk, rst_n (sync active-low)
//           instr_valid/instr_ready, instr_opcode, instr_dst, instr_src_a,
//           instr_src_b, instr_imm_sel, instr_imm - instruction in
//           alu_in_a, alu_in_b, alu_opcode - registered alu drive
//           alu_out, alu_flags {V,N,Z}      - alu response
//           flags_q                          - last written flags
//           wb_valid, wb_addr, wb_data       - writeback report (one cycle late)
//           dbg_addr, dbg_data               - combinational register peek
module alu_issue_stage
    import cpu_pkg::*;
#(
    parameter  int BW   = CPU_BW,
    parameter  int NREG = CPU_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  alu_op_t       instr_opcode,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_src_a,
    input  logic [AW-1:0] instr_src_b,
    input  logic          instr_imm_sel,
    input  logic [BW-1:0] instr_imm,
    output logic [BW-1:0] alu_in_a,
    output logic [BW-1:0] alu_in_b,
    output alu_op_t       alu_opcode,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic [2:0]    flags_q,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [BW-1:0] wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [BW-1:0] dbg_data
);

    logic          r_ex_valid;
    logic [AW-1:0] r_ex_dst;
    logic [BW-1:0] r_alu_in_a;
    logic [BW-1:0] r_alu_in_b;
    alu_op_t       r_alu_opcode;
    logic [2:0]    r_flags_q;
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_addr;
    logic [BW-1:0] r_wb_data;

    logic [BW-1:0] w_rdata_a;
    logic [BW-1:0] w_rdata_b;
    logic          w_ex_live;
    logic          w_match_a;
    logic          w_match_b;
    logic          w_hazard;
    logic          w_bypass_active;
    logic          w_fwd_a;
    logic          w_fwd_b;
    logic          w_accept;
    logic [BW-1:0] w_opnd_a;
    logic [BW-1:0] w_opnd_b;

    regfile #(
        .BW   (BW),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (r_ex_valid),
        .waddr    (r_ex_dst),
        .wdata    (alu_out),
        .raddr_a  (instr_src_a),
        .rdata_a  (w_rdata_a),
        .raddr_b  (instr_src_b),
        .rdata_b  (w_rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // An instruction in EX that will actually update a register. r0 results
    // are dropped, so a pending r0 write never creates a dependency.
    assign w_ex_live = r_ex_valid && (r_ex_dst != '0);
    assign w_match_a = w_ex_live && (instr_src_a == r_ex_dst);
    // Operand B only depends on the register file when the immediate is not used.
    assign w_match_b = w_ex_live && !instr_imm_sel && (instr_src_b == r_ex_dst);
    assign w_hazard  = w_match_a || w_match_b;

`ifdef ALU_ISSUE_BYPASS_EN
    // The result being written this edge is on alu_out right now; steer it
    // straight into the capture so the dependent op issues without a bubble.
    assign w_bypass_active = w_hazard;
    assign w_fwd_a         = w_match_a;
    assign w_fwd_b         = w_match_b;
`else
    // No forwarding: hold the dependent op one cycle, after which the
    // register file already holds the result.
    assign w_bypass_active = 1'b0;
    assign w_fwd_a         = 1'b0;
    assign w_fwd_b         = 1'b0;
`endif

    assign instr_ready = rst_n && !(w_hazard && !w_bypass_active);
    assign w_accept    = instr_valid && instr_ready;

    assign w_opnd_a = w_fwd_a       ? alu_out   : w_rdata_a;
    assign w_opnd_b = instr_imm_sel ? instr_imm :
                      w_fwd_b       ? alu_out   : w_rdata_b;

    // ISSUE: capture operands/opcode on accept, otherwise hold them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_dst     <= '0;
            r_alu_in_a   <= '0;
            r_alu_in_b   <= '0;
            r_alu_opcode <= ALU_ADD;
        end else if (w_accept) begin
            r_ex_valid   <= 1'b1;
            r_ex_dst     <= instr_dst;
            r_alu_in_a   <= w_opnd_a;
            r_alu_in_b   <= w_opnd_b;
            r_alu_opcode <= instr_opcode;
        end else begin
            r_ex_valid   <= 1'b0;
        end
    end

    // EX/WB: the register write itself happens inside the regfile on the same
    // edge; here flags are latched (even for r0) and the writeback is reported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags_q  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (r_ex_valid) begin
            r_flags_q  <= alu_flags;
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_ex_dst;
            r_wb_data  <= alu_out;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    assign alu_in_a   = r_alu_in_a;
    assign alu_in_b   = r_alu_in_b;
    assign alu_opcode = r_alu_opcode;
    assign flags_q    = r_flags_q;
    assign wb_valid   = r_wb_valid;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage with an alu model
module tb_alu_issue_stage;
    import cpu_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    alu_op_t       instr_opcode;
    logic [2:0]    instr_dst;
    logic [2:0]    instr_src_a;
    logic [2:0]    instr_src_b;
    logic          instr_imm_sel;
    logic [15:0]   instr_imm;
    logic [15:0]   alu_in_a;
    logic [15:0]   alu_in_b;
    alu_op_t       alu_opcode;
    logic [15:0]   alu_out;
    logic [2:0]    alu_flags;
    logic [2:0]    flags_q;
    logic          wb_valid;
    logic [2:0]    wb_addr;
    logic [15:0]   wb_data;
    logic [2:0]    dbg_addr;
    logic [15:0]   dbg_data;

    int n_vec  = 0;
    int n_fail = 0;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_dst     (instr_dst),
        .instr_src_a   (instr_src_a),
        .instr_src_b   (instr_src_b),
        .instr_imm_sel (instr_imm_sel),
        .instr_imm     (instr_imm),
        .alu_in_a      (alu_in_a),
        .alu_in_b      (alu_in_b),
        .alu_opcode    (alu_opcode),
        .alu_out       (alu_out),
        .alu_flags     (alu_flags),
        .flags_q       (flags_q),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational alu standing in for the real one.
    logic [15:0] m_res;
    logic        m_v;
    always_comb begin
        m_res = '0;
        m_v   = 1'b0;
        case (alu_opcode)
            ALU_ADD: begin
                m_res = alu_in_a + alu_in_b;
                m_v   = (alu_in_a[15] == alu_in_b[15]) && (m_res[15] != alu_in_a[15]);
            end
            ALU_SUB: begin
                m_res = alu_in_a - alu_in_b;
                m_v   = (alu_in_a[15] != alu_in_b[15]) && (m_res[15] != alu_in_a[15]);
            end
            ALU_AND: m_res = alu_in_a & alu_in_b;
            ALU_OR:  m_res = alu_in_a | alu_in_b;
            ALU_XOR: m_res = alu_in_a ^ alu_in_b;
            ALU_SHL: m_res = alu_in_a << alu_in_b[3:0];
            ALU_SHR: m_res = alu_in_a >> alu_in_b[3:0];
            default: m_res = alu_in_b;
        endcase
    end
    assign alu_out = m_res;
    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_V] = m_v;
        alu_flags[FLAG_N] = m_res[15];
        alu_flags[FLAG_Z] = (m_res == '0);
    end

    typedef struct {
        alu_op_t     op;
        logic [2:0]  dst;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic        imm_sel;
        logic [15:0] imm;
        logic [15:0] exp_data;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input alu_op_t op, input logic [2:0] dst, input logic [2:0] sa,
                         input logic [2:0] sb, input logic imm_sel, input logic [15:0] imm);
        instr_valid   = 1'b1;
        instr_opcode  = op;
        instr_dst     = dst;
        instr_src_a   = sa;
        instr_src_b   = sb;
        instr_imm_sel = imm_sel;
        instr_imm     = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(name, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    int stalls;
    int exp_stalls;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5,    16'h0005, 3'b000};
        tbl[1] = '{ALU_ADD, 3'd0, 3'd1, 3'd0, 1'b1, 16'hFFFB, 16'h0000, 3'b001};
        tbl[2] = '{ALU_SUB, 3'd5, 3'd1, 3'd0, 1'b1, 16'd7,    16'hFFFE, 3'b010};
        tbl[3] = '{ALU_AND, 3'd6, 3'd1, 3'd5, 1'b0, 16'h0000, 16'h0004, 3'b000};
        tbl[4] = '{ALU_OR,  3'd7, 3'd5, 3'd1, 1'b0, 16'h0000, 16'hFFFF, 3'b010};
        tbl[5] = '{ALU_XOR, 3'd3, 3'd7, 3'd7, 1'b0, 16'h0000, 16'h0000, 3'b001};
        tbl[6] = '{ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 16'h7FFF, 3'b000};
        tbl[7] = '{ALU_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h8000, 3'b110};
        tbl[8] = '{ALU_SUB, 3'd2, 3'd3, 3'd0, 1'b1, 16'h0001, 16'h7FFF, 3'b100};
        tbl[9] = '{ALU_SHL, 3'd4, 3'd7, 3'd0, 1'b1, 16'h0004, 16'hFFF0, 3'b010};

        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_opcode  = ALU_ADD;
        instr_dst     = '0;
        instr_src_a   = '0;
        instr_src_b   = '0;
        instr_imm_sel = 1'b0;
        instr_imm     = '0;
        dbg_addr      = '0;

        // Reset held two cycles.
        step();
        step();
        chk("reset_ready", {31'h0, instr_ready}, 32'h0);
        chk("reset_flags", {29'h0, flags_q}, 32'h0);
        chk("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("reset_alu_in_a", {16'h0, alu_in_a}, 32'h0);
        for (int a = 0; a < 8; a++) peek("reset_dbg", 3'(a), 16'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'h0, instr_ready}, 32'h1);

        // Dependent pair: r1 = 5, then r2 = r1 + 3 back to back.
`ifdef ALU_ISSUE_BYPASS_EN
        exp_stalls = 0;
`else
        exp_stalls = 1;
`endif
        drive(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
        step();
        drive(ALU_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'd3);
        #1;
        stalls = 0;
        while (!instr_ready && stalls < 4) begin
            step();
            stalls++;
        end
        chk("dep_stall_cycles", 32'(stalls), 32'(exp_stalls));
        step();
        // imm_sel=1 with src_b naming the in-flight dst must not stall.
        drive(ALU_ADD, 3'd3, 3'd0, 3'd2, 1'b1, 16'd9);
        #1;
        chk("imm_srcb_no_hazard", {31'h0, instr_ready}, 32'h1);
        step();
        instr_valid = 1'b0;
        chk("dep_wb_addr", {29'h0, wb_addr}, 32'h2);
        chk("dep_wb_data", {16'h0, wb_data}, 32'h8);
        step();
        chk("imm_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("imm_wb_data", {16'h0, wb_data}, 32'h9);
        step();
        chk("wb_valid_drops", {31'h0, wb_valid}, 32'h0);
        peek("dep_r1", 3'd1, 16'h0005);
        peek("dep_r2", 3'd2, 16'h0008);
        peek("dep_r3", 3'd3, 16'h0009);

        // Independent vectors, one at a time.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm_sel, tbl[i].imm);
            #1;
            chk("vec_ready", {31'h0, instr_ready}, 32'h1);
            step();
            instr_valid = 1'b0;
            step();
            chk("vec_wb_valid", {31'h0, wb_valid}, 32'h1);
            chk("vec_wb_addr", {29'h0, wb_addr}, {29'h0, tbl[i].dst});
            chk("vec_wb_data", {16'h0, wb_data}, {16'h0, tbl[i].exp_data});
            chk("vec_flags", {29'h0, flags_q}, {29'h0, tbl[i].exp_flags});
            peek("vec_reg", tbl[i].dst, (tbl[i].dst == 3'd0) ? 16'h0 : tbl[i].exp_data);
        end

        // Reset lands on the edge after accept: the in-flight op is lost.
        drive(ALU_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'h1234);
        step();
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        step();
        chk("midrst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("midrst_ready", {31'h0, instr_ready}, 32'h0);
        chk("midrst_flags", {29'h0, flags_q}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("midrst_wb_after", {31'h0, wb_valid}, 32'h0);
        peek("midrst_r5", 3'd5, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
